// File: rtl/obstacle_sched_pkg.sv
// Shared state encoding, widths and default timing for the obstacle scheduler.
package obstacle_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_REQ  = 2'd2
  } state_e;

  localparam int         LANE_W    = 2;
  localparam int         LEVEL_W   = 4;
  localparam logic [3:0] LEVEL_MAX = 4'd15;

  localparam int          DEF_BASE_INTERVAL = 50_000_000;
  localparam int          DEF_INTERVAL_STEP = 2_500_000;
  localparam int          DEF_MIN_INTERVAL  = 12_500_000;
  localparam int          DEF_LEVEL_POINTS  = 10;
  localparam int          DEF_TICK_BASE     = 1_000_000;
  localparam int          DEF_TICK_STEP     = 50_000;
  localparam int          DEF_TICK_MIN      = 250_000;
  localparam logic [15:0] DEF_LFSR_SEED     = 16'hACE1;

  // Period shrinks linearly with level but never wraps and never drops below the floor.
  function automatic logic [31:0] floored_period(input logic [31:0]        base,
                                                 input logic [31:0]        step,
                                                 input logic [LEVEL_W-1:0] lvl,
                                                 input logic [31:0]        floor_v);
    logic [31:0] dec;
    dec = step * 32'(lvl);
    if (dec >= base || (base - dec) < floor_v) floored_period = floor_v;
    else                                       floored_period = base - dec;
  endfunction

endpackage

// File: rtl/obstacle_scheduler_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running from the seed.
module lfsr16 (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;

  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
  // NOTE: reset is synchronous; it only takes effect on a rising Clock edge.
  always_ff @(posedge Clock) begin
    if (!Resetn) q_q <= seed;
    else         q_q <= {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
  end

  assign q = q_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Paces obstacle spawns and the advance tick, both speeding up with the score-derived level.
module obstacle_scheduler
  import obstacle_sched_pkg::*;
#(
  parameter int          NUM_LANES     = 3,
  parameter int          BASE_INTERVAL = DEF_BASE_INTERVAL,
  parameter int          INTERVAL_STEP = DEF_INTERVAL_STEP,
  parameter int          MIN_INTERVAL  = DEF_MIN_INTERVAL,
  parameter int          LEVEL_POINTS  = DEF_LEVEL_POINTS,
  parameter int          TICK_BASE     = DEF_TICK_BASE,
  parameter int          TICK_STEP     = DEF_TICK_STEP,
  parameter int          TICK_MIN      = DEF_TICK_MIN,
  parameter logic [15:0] LFSR_SEED     = DEF_LFSR_SEED
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               enable,
  input  logic [15:0]        score,
  input  logic               spawn_ack,
  output logic               spawn_req,
  output logic [LANE_W-1:0]  spawn_lane,
  output logic [LEVEL_W-1:0] level,
  output logic               move_tick
);

  state_e             state_q, state_d;
  logic [31:0]        cnt_q, cnt_d, ivl_q, ivl_d;
  logic [LANE_W-1:0]  lane_q, lane_d, last_q, last_d, prev_q, prev_d, cand;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [31:0]        tick_cnt_q, tick_cnt_d, tick_per_q, tick_per_d;
  logic               tick_q, tick_d;
  logic [31:0]        spawn_ivl, tick_ivl;
  logic [15:0]        score_lvl, lfsr_q;
  logic               unused_lfsr;

  function automatic logic [LANE_W-1:0] lane_inc(input logic [LANE_W-1:0] l);
    return (l == LANE_W'(NUM_LANES - 1)) ? '0 : l + LANE_W'(1);
  endfunction

  lfsr16 u_lfsr (.Clock(Clock), .Resetn(Resetn), .seed(LFSR_SEED), .q(lfsr_q));
  assign unused_lfsr = ^lfsr_q[15:LANE_W];

  assign score_lvl = score / 16'(LEVEL_POINTS);
  assign level_d   = (score_lvl > 16'(LEVEL_MAX)) ? LEVEL_MAX : score_lvl[LEVEL_W-1:0];

  assign spawn_ivl = floored_period(32'(BASE_INTERVAL), 32'(INTERVAL_STEP), level_q, 32'(MIN_INTERVAL));
  assign tick_ivl  = floored_period(32'(TICK_BASE), 32'(TICK_STEP), level_q, 32'(TICK_MIN));

  // Out-of-range candidate rotates past the last lane; a third repeat is bumped to the next lane.
  always_comb begin
    cand = lfsr_q[LANE_W-1:0];
    if (cand >= LANE_W'(NUM_LANES)) cand = lane_inc(last_q);
    if (cand == last_q && cand == prev_q) cand = lane_inc(cand);
  end

  // NOTE: every signal gets its default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ivl_d   = ivl_q;
    lane_d  = lane_q;
    last_d  = last_q;
    prev_d  = prev_q;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT;
          cnt_d   = '0;
          ivl_d   = spawn_ivl;
        end
        ST_WAIT: begin
          if (cnt_q == ivl_q - 32'd1) begin
            state_d = ST_REQ;
            lane_d  = cand;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        ST_REQ: begin
          if (spawn_ack) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
            ivl_d   = spawn_ivl;
            prev_d  = last_q;
            last_d  = lane_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // The tick period is only sampled at a reload, so a level change never truncates a tick.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    tick_per_d = tick_per_q;
    tick_d     = 1'b0;
    if (!enable) begin
      tick_cnt_d = '0;
      tick_per_d = tick_ivl;
    end else if (tick_cnt_q == tick_per_q - 32'd1) begin
      tick_d     = 1'b1;
      tick_cnt_d = '0;
      tick_per_d = tick_ivl;
    end else begin
      tick_cnt_d = tick_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ivl_q      <= '0;
      lane_q     <= '0;
      last_q     <= '0;
      prev_q     <= '0;
      level_q    <= '0;
      tick_cnt_q <= '0;
      tick_per_q <= 32'(TICK_BASE);
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ivl_q      <= ivl_d;
      lane_q     <= lane_d;
      last_q     <= last_d;
      prev_q     <= prev_d;
      level_q    <= level_d;
      tick_cnt_q <= tick_cnt_d;
      tick_per_q <= tick_per_d;
      tick_q     <= tick_d;
    end
  end

  assign spawn_req  = (state_q == ST_REQ);
  assign spawn_lane = lane_q;
  assign level      = level_q;
  assign move_tick  = tick_q;

endmodule
